// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int unsigned FRAME_BITS = 11;

  // Bit positions inside the sticky err vector {overflow, framing, parity}
  localparam int unsigned ERR_PARITY   = 0;
  localparam int unsigned ERR_FRAMING  = 1;
  localparam int unsigned ERR_OVERFLOW = 2;

  // True when data plus parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Receive FIFO for ps2_rx: synchronous, power-of-two depth, registered head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ps2_rx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_core,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     rd_ready,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ps2_rx_fifo: DEPTH must be a power of two >= 2");
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   count_next;
  logic          full;
  logic          pop;
  logic          push_ok;

  // Handshake qualification and next pointer/count values
  always_comb begin
    full        = (count == FULL_COUNT);
    pop         = rd_ready && (count != '0);
    push_ok     = push && (!full || pop);
    overflow    = push && full && !pop;
    rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_next  = count;
    if (push_ok && !pop) begin
      count_next = count + 1'b1;
    end else if (!push_ok && pop) begin
      count_next = count - 1'b1;
    end
    rd_valid = (count != '0);
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk_core) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
    end
  end

  // Registered head: preloads the next entry, bypassing the write when the
  // slot being written is the one that becomes the head.
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (count_next != '0) begin
      rd_data <= (push_ok && (wr_ptr == rd_ptr_next)) ? push_data : mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver with receive FIFO, sticky error flags and
// host-side clock inhibit. Optional frame timeout enabled by defining
// PS2_RX_TIMEOUT_EN.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 2_500_000,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk_core,
  input  logic       reset_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic       inhibit,
  output logic       clk_oe,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [2:0] err,
  input  logic       clear_err
);

  localparam int unsigned DATA_BITS = FRAME_BITS - 3;
  localparam int unsigned CNT_W     = $clog2(DATA_BITS);
  localparam int unsigned FCW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FCW-1:0] OE_LEVEL = FCW'(FIFO_DEPTH - 1);

  if (CLK_HZ / 1_000_000 * TIMEOUT_US < 2) begin : g_bad_timeout
    $error("ps2_rx: timeout must span at least two core cycles");
  end

  logic             clk_s1, clk_s2, clk_s3;
  logic             dat_s1, dat_s2;
  logic             fall;
  ps2_state_e       state, state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       shift_reg;
  logic             parity_bit;
  logic             push;
  logic             abort;
  logic             timeout_hit;
  logic             clk_oe_q;
  logic [2:0]       fsm_err;
  logic [2:0]       err_set;
  logic [FCW-1:0]   fifo_count;
  logic             fifo_overflow;

  // Two-flop synchronizers plus a third clock flop for fall detection
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_data_in;
      dat_s2 <= dat_s1;
    end
  end

  // Fall strobe and clk_oe-rise abort qualifier
  always_comb begin
    fall  = clk_s3 && !clk_s2;
    abort = (state != ST_IDLE) && clk_oe && !clk_oe_q;
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TO_LIMIT = CLK_HZ / 1_000_000 * TIMEOUT_US - 1;
  localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

  logic [TO_W-1:0] to_cnt;

  // Inter-fall gap counter, held at zero while idle
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (state == ST_IDLE || fall) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_W'(TO_LIMIT)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Gap limit reached while a frame is in progress
  always_comb begin
    timeout_hit = (state != ST_IDLE) && (to_cnt == TO_W'(TO_LIMIT));
  end
`else
  // Frames only end through STOP, clk_oe abort or reset
  always_comb begin
    timeout_hit = 1'b0;
  end
`endif

  // Frame state register
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, push strobe and frame error flags; aborts take priority
  always_comb begin
    state_next = state;
    push       = 1'b0;
    fsm_err    = '0;
    if (abort) begin
      state_next = ST_IDLE;
    end else if (timeout_hit) begin
      state_next           = ST_IDLE;
      fsm_err[ERR_FRAMING] = 1'b1;
    end else if (fall) begin
      case (state)
        ST_IDLE: begin
          if (!dat_s2) begin
            state_next = ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
            state_next = ST_PARITY;
          end
        end
        ST_PARITY: begin
          state_next = ST_STOP;
        end
        ST_STOP: begin
          state_next = ST_IDLE;
          if (dat_s2 && odd_parity_ok(shift_reg, parity_bit)) begin
            push = 1'b1;
          end else begin
            fsm_err[ERR_FRAMING] = !dat_s2;
            fsm_err[ERR_PARITY]  = !odd_parity_ok(shift_reg, parity_bit);
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Data shift register, bit counter and parity capture
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
    end else if (fall && !abort && !timeout_hit) begin
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
        end
        ST_DATA: begin
          shift_reg <= {dat_s2, shift_reg[7:1]};
          bit_cnt   <= bit_cnt + 1'b1;
        end
        ST_PARITY: begin
          parity_bit <= dat_s2;
        end
        default: begin
        end
      endcase
    end
  end

  ps2_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_core (clk_core),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(shift_reg),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (fifo_count),
    .overflow (fifo_overflow)
  );

  // Host clock hold-off: explicit inhibit or FIFO nearly full
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      clk_oe   <= 1'b0;
      clk_oe_q <= 1'b0;
    end else begin
      clk_oe   <= inhibit || (fifo_count >= OE_LEVEL);
      clk_oe_q <= clk_oe;
    end
  end

  // Merge frame and FIFO error sources
  always_comb begin
    err_set               = fsm_err;
    err_set[ERR_OVERFLOW] = fifo_overflow;
  end

  // Sticky error flags; a new error wins over a same-cycle clear
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      err <= '0;
    end else begin
      err <= (clear_err ? 3'b000 : err) | err_set;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed scenarios plus randomized frames,
// compared against a byte-queue model of the receiver.
module tb_ps2_rx;

  localparam int D = 8;
  localparam int H = 8;
  localparam int TO_WAIT = (2000 + 10) * 5 / 2;

  logic       clk_core    = 1'b0;
  logic       reset_n     = 1'b0;
  logic       ps2_clk_in  = 1'b1;
  logic       ps2_data_in = 1'b1;
  logic       inhibit     = 1'b0;
  logic       rd_ready    = 1'b0;
  logic       clear_err   = 1'b0;
  logic       clk_oe;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] err;

  int         tests = 0;
  int         fails = 0;
  bit         settled = 1'b0;
  logic [7:0] mq[$];
  logic [2:0] m_err = 3'b000;

  always #5 clk_core = ~clk_core;

  ps2_rx #(
    .CLK_HZ    (2_500_000),
    .TIMEOUT_US(2000),
    .FIFO_DEPTH(D)
  ) dut (
    .clk_core   (clk_core),
    .reset_n    (reset_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .inhibit    (inhibit),
    .clk_oe     (clk_oe),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .err        (err),
    .clear_err  (clear_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model whenever outputs are settled
  always @(negedge clk_core) begin
    if (settled && reset_n) begin
      check("valid", 32'(mq.size() != 0), 32'(rd_valid));
      if (mq.size() != 0) check("data", 32'(rd_data), 32'(mq[0]));
      check("err", 32'(err), 32'(m_err));
      check("clk_oe", 32'(clk_oe), 32'(inhibit || (mq.size() >= D - 1)));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par,
                                             input logic bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_core);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data_in = b;
    wait_cyc(H);
    ps2_clk_in = 1'b0;
    wait_cyc(H);
    ps2_clk_in = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit(f[i]);
  endtask

  // Stop bit with optional same-cycle pop/clear at the push edge, then model update
  task automatic finish_frame(input logic [10:0] f, input bit pop_at, input bit clr_at,
                              input bit tcheck);
    bit good;
    settled = 1'b0;
    ps2_data_in = f[10];
    wait_cyc(H);
    ps2_clk_in = 1'b0;
    @(posedge clk_core);
    @(posedge clk_core);
    #1;
    rd_ready  = pop_at;
    clear_err = clr_at;
    @(negedge clk_core);
    if (tcheck) check("valid_before_push", 32'(rd_valid), 32'd0);
    @(posedge clk_core);
    #1;
    rd_ready  = 1'b0;
    clear_err = 1'b0;
    @(negedge clk_core);
    if (tcheck) check("valid_after_push", 32'(rd_valid), 32'd1);
    wait_cyc(H);
    ps2_clk_in = 1'b1;
    wait_cyc(2);
    ps2_data_in = 1'b1;
    wait_cyc(2);
    good = f[10] && ($countones(f[9:1]) % 2 == 1);
    if (clr_at) m_err = 3'b000;
    if (!f[10]) m_err[1] = 1'b1;
    if ($countones(f[9:1]) % 2 == 0) m_err[0] = 1'b1;
    if (good && mq.size() == D && !pop_at) begin
      m_err[2] = 1'b1;
    end else begin
      if (pop_at && mq.size() != 0) void'(mq.pop_front());
      if (good) mq.push_back(f[8:1]);
    end
    settled = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic [10:0] f;
    f = make_frame(b, bad_par, bad_stop);
    send_bits(f, 10);
    finish_frame(f, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    if (mq.size() != 0) begin
      settled  = 1'b0;
      rd_ready = 1'b1;
      wait_cyc(1);
      rd_ready = 1'b0;
      void'(mq.pop_front());
      wait_cyc(3);
      settled = 1'b1;
    end
  endtask

  task automatic do_clear();
    settled   = 1'b0;
    clear_err = 1'b1;
    wait_cyc(1);
    clear_err = 1'b0;
    m_err     = 3'b000;
    wait_cyc(1);
    settled = 1'b1;
  endtask

  task automatic set_inhibit(input logic v);
    settled = 1'b0;
    inhibit = v;
    wait_cyc(3);
    settled = 1'b1;
  endtask

  initial begin
    logic [10:0] f;
    int unsigned r;
    int unsigned npop;

    // Reset values
    wait_cyc(3);
    @(negedge clk_core);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", 32'(rd_data), 32'h00);
    check("rst_err", 32'(err), 32'd0);
    check("rst_clk_oe", 32'(clk_oe), 32'd0);
    wait_cyc(1);
    reset_n = 1'b1;
    wait_cyc(3);
    settled = 1'b1;

    // Good frame 0x1C with push/valid timing
    f = make_frame(8'h1C, 1'b0, 1'b0);
    send_bits(f, 10);
    finish_frame(f, 1'b0, 1'b0, 1'b1);
    check("f1c_data", 32'(rd_data), 32'h1C);
    check("f1c_err", 32'(err), 32'd0);
    pop_one();

    // Bad parity, then clear
    send_frame(8'hF0, 1'b1, 1'b0);
    check("parity_err", 32'(err), 32'b001);
    check("parity_nopush", 32'(rd_valid), 32'd0);
    do_clear();
    check("cleared", 32'(err), 32'd0);

    // Bad stop, then bad parity with a clear on the same edge
    send_frame(8'h33, 1'b0, 1'b1);
    check("stop_err", 32'(err), 32'b010);
    f = make_frame(8'h55, 1'b1, 1'b0);
    send_bits(f, 10);
    finish_frame(f, 1'b0, 1'b1, 1'b0);
    check("clear_vs_set", 32'(err), 32'b001);
    do_clear();

    // Fill past depth with no reads
    for (int i = 0; i < D + 1; i++) begin
      send_frame(8'hA0 + 8'(i), 1'b0, 1'b0);
      if (i == D - 3) check("oe_below_level", 32'(clk_oe), 32'd0);
      if (i == D - 2) check("oe_at_level", 32'(clk_oe), 32'd1);
    end
    check("overflow_err", 32'(err), 32'b100);
    check("full_head", 32'(rd_data), 32'hA0);
    do_clear();

    // Push and pop together while full
    f = make_frame(8'h77, 1'b0, 1'b0);
    send_bits(f, 10);
    finish_frame(f, 1'b1, 1'b0, 1'b0);
    check("full_pushpop_err", 32'(err), 32'd0);
    check("full_pushpop_head", 32'(rd_data), 32'hA1);
    while (mq.size() != 0) pop_one();
    check("drained", 32'(rd_valid), 32'd0);

    // Inhibit mid-frame aborts cleanly
    f = make_frame(8'h3C, 1'b0, 1'b0);
    send_bits(f, 5);
    set_inhibit(1'b1);
    check("inhibit_oe", 32'(clk_oe), 32'd1);
    check("inhibit_err", 32'(err), 32'd0);
    ps2_data_in = 1'b1;
    wait_cyc(4);
    set_inhibit(1'b0);
    check("uninhibit_oe", 32'(clk_oe), 32'd0);
    send_frame(8'hE7, 1'b0, 1'b0);
    check("after_inhibit", 32'(rd_data), 32'hE7);
    check("after_inhibit_err", 32'(err), 32'd0);
    pop_one();

    // Reset mid-frame; the tail of the old frame must be ignored
    f = make_frame(8'hFF, 1'b0, 1'b0);
    send_bits(f, 5);
    settled = 1'b0;
    reset_n = 1'b0;
    wait_cyc(2);
    reset_n = 1'b1;
    mq.delete();
    m_err = 3'b000;
    wait_cyc(3);
    settled = 1'b1;
    for (int i = 5; i < 11; i++) send_bit(f[i]);
    wait_cyc(6);
    check("rst_frame_nopush", 32'(rd_valid), 32'd0);
    check("rst_frame_err", 32'(err), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0);
    check("post_rst_frame", 32'(rd_data), 32'h5A);
    pop_one();

`ifdef PS2_RX_TIMEOUT_EN
    // Stalled device clock times out
    f = make_frame(8'h12, 1'b0, 1'b0);
    send_bits(f, 6);
    settled = 1'b0;
    ps2_data_in = 1'b1;
    wait_cyc(TO_WAIT);
    m_err[1] = 1'b1;
    settled = 1'b1;
    check("timeout_err", 32'(err), 32'b010);
    send_frame(8'h5A, 1'b0, 1'b0);
    check("post_timeout", 32'(rd_data), 32'h5A);
    pop_one();
    do_clear();
`endif

    // Randomized traffic: slow drain first (overflow likely), then fast drain
    for (int n = 0; n < 60; n++) begin
      r    = $urandom_range(0, 9);
      npop = (n < 30) ? $urandom_range(0, 1) : $urandom_range(0, 3);
      for (int k = 0; k < int'(npop); k++) pop_one();
      if ($urandom_range(0, 7) == 0) do_clear();
      send_frame(8'($urandom), r == 0, r == 1);
    end
    while (mq.size() != 0) pop_one();
    wait_cyc(4);
    settled = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 2_500_000, frequency of clk_core in Hz.
REQ-002 SHALL have parameter TIMEOUT_US, default 2000, maximum gap between device clock falls inside a frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries, power of two >= 2.
REQ-004 SHALL have port clk_core  input  1  core clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ps2_clk_in  input  1  raw PS/2 clock pin, asynchronous.
REQ-007 SHALL have port ps2_data_in  input  1  raw PS/2 data pin, asynchronous.
REQ-008 SHALL have port inhibit  input  1  host request to hold the device off.
REQ-009 SHALL have port clk_oe  output  1  high drives the PS/2 clock pin low (open-drain pull-down).
REQ-010 SHALL have port rd_data  output  8  byte at FIFO head.
REQ-011 SHALL have port rd_valid  output  1  FIFO not empty.
REQ-012 SHALL have port rd_ready  input  1  consumer pops head when rd_valid and rd_ready are both high.
REQ-013 SHALL have port err  output  3  sticky {overflow, framing, parity}.
REQ-014 SHALL have port clear_err  input  1  single-cycle clear of all err bits.

Function
REQ-015 SHALL pass both pins through 2-flop synchronizers; both flops reset to 1.
REQ-016 SHALL detect a fall when the previous synchronized clock is 1 and the current one is 0; a pin fall SHALL be detected exactly 3 cycles later.
REQ-017 SHALL use the FSM IDLE->DATA->PARITY->STOP->IDLE, advancing only on a detected fall.
REQ-018 IDLE: a fall with data=0 (start bit) SHALL enter DATA with bit count 0; a fall with data=1 SHALL be ignored.
REQ-019 DATA: SHALL shift in 8 bits LSB-first, then go to PARITY; PARITY SHALL sample one bit.
REQ-020 STOP: if stop=1 and data^parity has odd parity, SHALL push the byte in that same cycle; otherwise SHALL drop the byte and set err[1] (bad stop) or err[0] (bad parity); state SHALL then return to IDLE.
REQ-021 rd_valid SHALL rise on the cycle after the push.
REQ-022 Push with FIFO full and no pop SHALL drop the byte and set err[2]; a simultaneous push and pop while full SHALL accept the push.
REQ-023 clk_oe SHALL equal inhibit OR (FIFO count >= FIFO_DEPTH-1), registered.
REQ-024 A rising clk_oe in any non-IDLE state SHALL abort to IDLE on the next cycle with no error and no push.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-026 clear_err SHALL be overridden by any error set in the same cycle.

Reset
REQ-027 On reset: state IDLE, FIFO empty, rd_valid=0, rd_data=0, err=0, clk_oe=0, shift register 0, timeout counter 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; no push SHALL follow reset release until a new start bit arrives.

Configuration
REQ-029 With PS2_RX_TIMEOUT_EN defined: a counter SHALL clear on every fall and in IDLE; reaching CLK_HZ/1_000_000*TIMEOUT_US-1 outside IDLE SHALL abort to IDLE and set err[1].
REQ-030 Without PS2_RX_TIMEOUT_EN: no counter SHALL exist; frames end only via STOP, clk_oe abort or reset.

Structure
REQ-031 Package ps2_pkg SHALL hold the state enum, the FRAME_BITS=11 constant and the err bit indices.
REQ-032 The FIFO SHALL be the sub-module ps2_rx_fifo (synchronous, registered head); everything else SHALL be inline.

Verification
REQ-033 Frame 0x1C with odd parity 0 and stop 1 -> rd_data=0x1C, rd_valid one cycle after the push, err=0.
REQ-034 Frame 0xF0 with wrong parity -> no push, err=3'b001; clear_err pulse -> err=0.
REQ-035 Send FIFO_DEPTH+1 frames with rd_ready=0 -> clk_oe high at depth-1, last byte dropped, err[2]=1; pop once while pushing -> no loss.
REQ-036 Assert inhibit after 4 data bits -> clk_oe=1, FSM IDLE, no error; next full frame received intact.
REQ-037 (PS2_RX_TIMEOUT_EN) Stop the clock after 5 data bits for TIMEOUT_US+10 us -> err[1]=1, IDLE; next frame 0x5A received correctly.
